// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the Common Data Bus.
// Grants one holding FU per cycle and registers its result onto the CDB.
module cdb_arbiter #(
  parameter int NUM_FU         = 4,
  parameter int PHYS_REG_WIDTH = 6,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             cdb_stall,
  input  logic [NUM_FU-1:0]                fu_valid,
  input  logic [NUM_FU*DATA_WIDTH-1:0]     fu_result,
  input  logic [NUM_FU*PHYS_REG_WIDTH-1:0] fu_dest_tag,
  input  logic [NUM_FU-1:0]                fu_dest_tag_wr_en,
  output logic [NUM_FU-1:0]                fu_broadcasted,
  output logic                             cdb_valid,
  output logic [DATA_WIDTH-1:0]            cdb_value,
  output logic [PHYS_REG_WIDTH-1:0]        cdb_tag,
  output logic                             cdb_wr_en
);

  localparam int PTR_W = (NUM_FU > 2) ? $clog2(NUM_FU) : 1;

  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic                      valid_q, valid_d;
  logic [DATA_WIDTH-1:0]     value_q, value_d;
  logic [PHYS_REG_WIDTH-1:0] tag_q, tag_d;
  logic                      wr_en_q, wr_en_d;

  logic                      blocked;
  logic                      gnt_vld;
  logic [PTR_W-1:0]          gnt_idx;
  logic [NUM_FU-1:0]         gnt;
  logic [DATA_WIDTH-1:0]     sel_value;
  logic [PHYS_REG_WIDTH-1:0] sel_tag;
  logic                      sel_wr_en;
  int                        idx;

  assign blocked = reset | clear | cdb_stall;

  // Search starts at ptr and wraps explicitly, so any NUM_FU works.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (!blocked && !gnt_vld && fu_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'(idx);
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

  assign fu_broadcasted = gnt;

  always_comb begin
    sel_value = fu_result[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    sel_tag   = fu_dest_tag[int'(gnt_idx)*PHYS_REG_WIDTH +: PHYS_REG_WIDTH];
    sel_wr_en = fu_dest_tag_wr_en[gnt_idx];
  end

  always_comb begin
    ptr_d   = ptr_q;
    valid_d = 1'b0;
    value_d = value_q;
    tag_d   = tag_q;
    wr_en_d = wr_en_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (cdb_stall) begin
      valid_d = valid_q;
    end else if (gnt_vld) begin
      valid_d = 1'b1;
      value_d = sel_value;
      tag_d   = sel_tag;
      wr_en_d = sel_wr_en;
      ptr_d   = (gnt_idx == PTR_W'(NUM_FU - 1)) ? '0
                                                 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      value_q <= '0;
      tag_q   <= '0;
      wr_en_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      value_q <= value_d;
      tag_q   <= tag_d;
      wr_en_q <= wr_en_d;
    end
  end

  assign cdb_valid = valid_q;
  assign cdb_value = value_q;
  assign cdb_tag   = tag_q;
  assign cdb_wr_en = wr_en_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a 4-FU and a 3-FU instance
// share control inputs and are compared with a behavioural model.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int N3 = 3;
  localparam int DW = 32;
  localparam int TW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr, stl;

  logic [N-1:0]     fv, fwe, fb;
  logic [N*DW-1:0]  fres;
  logic [N*TW-1:0]  ftag;
  logic             cv, cwe;
  logic [DW-1:0]    cval;
  logic [TW-1:0]    ctag;

  logic [N3-1:0]    fv3, fwe3, fb3;
  logic [N3*DW-1:0] fres3;
  logic [N3*TW-1:0] ftag3;
  logic             cv3, cwe3;
  logic [DW-1:0]    cval3;
  logic [TW-1:0]    ctag3;

  cdb_arbiter #(.NUM_FU(N), .PHYS_REG_WIDTH(TW), .DATA_WIDTH(DW)) u4 (
    .clock(clk), .reset(rst), .clear(clr), .cdb_stall(stl),
    .fu_valid(fv), .fu_result(fres), .fu_dest_tag(ftag),
    .fu_dest_tag_wr_en(fwe), .fu_broadcasted(fb),
    .cdb_valid(cv), .cdb_value(cval), .cdb_tag(ctag), .cdb_wr_en(cwe)
  );

  cdb_arbiter #(.NUM_FU(N3), .PHYS_REG_WIDTH(TW), .DATA_WIDTH(DW)) u3 (
    .clock(clk), .reset(rst), .clear(clr), .cdb_stall(stl),
    .fu_valid(fv3), .fu_result(fres3), .fu_dest_tag(ftag3),
    .fu_dest_tag_wr_en(fwe3), .fu_broadcasted(fb3),
    .cdb_valid(cv3), .cdb_value(cval3), .cdb_tag(ctag3), .cdb_wr_en(cwe3)
  );

  typedef struct {
    int          cyc;
    logic        v   [2];
    logic [DW-1:0] val [2];
    logic [TW-1:0] tag [2];
    logic        we  [2];
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;
  int ec       = 0;

  always @(posedge clk) ec <= ec + 1;

  int            mp   [2];
  logic          mv   [2];
  logic [DW-1:0] mval [2];
  logic [TW-1:0] mtag [2];
  logic          mwe  [2];

  function automatic int pick(logic [15:0] v, int p, int n);
    for (int k = 0; k < n; k++)
      if (v[(p + k) % n]) return (p + k) % n;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, ec, act, exp);
    end
  endtask

  task automatic step(input logic [N-1:0] v, input logic [N3-1:0] v3,
                      input logic c, input logic s, input logic r);
    int   g [2];
    int   n;
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; clr = c; stl = s; fv = v; fv3 = v3;
    for (int i = 0; i < N; i++) begin
      fres[i*DW +: DW] = $urandom;
      ftag[i*TW +: TW] = TW'($urandom);
      fwe[i]           = 1'($urandom);
    end
    for (int i = 0; i < N3; i++) begin
      fres3[i*DW +: DW] = $urandom;
      ftag3[i*TW +: TW] = TW'($urandom);
      fwe3[i]           = 1'($urandom);
    end
    #1;
    g[0] = (r || c || s) ? -1 : pick(16'(v), mp[0], N);
    g[1] = (r || c || s) ? -1 : pick(16'(v3), mp[1], N3);
    chk("grant4", 64'(fb), (g[0] < 0) ? 64'd0 : (64'd1 << g[0]));
    chk("grant3", 64'(fb3), (g[1] < 0) ? 64'd0 : (64'd1 << g[1]));
    for (int u = 0; u < 2; u++) begin
      n = (u == 0) ? N : N3;
      if (r) begin
        mv[u] = 1'b0; mval[u] = '0; mtag[u] = '0; mwe[u] = 1'b0; mp[u] = 0;
      end else if (c) begin
        mv[u] = 1'b0;
      end else if (s) begin
        mv[u] = mv[u];
      end else if (g[u] >= 0) begin
        mv[u] = 1'b1;
        if (u == 0) begin
          mval[u] = fres[g[u]*DW +: DW];
          mtag[u] = ftag[g[u]*TW +: TW];
          mwe[u]  = fwe[g[u]];
        end else begin
          mval[u] = fres3[g[u]*DW +: DW];
          mtag[u] = ftag3[g[u]*TW +: TW];
          mwe[u]  = fwe3[g[u]];
        end
        mp[u] = (g[u] + 1) % n;
      end else begin
        mv[u] = 1'b0;
      end
      e.v[u] = mv[u]; e.val[u] = mval[u];
      e.tag[u] = mtag[u]; e.we[u] = mwe[u];
    end
    e.cyc = ec;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      while (q.size() > 0 && q[0].cyc + 1 == ec) begin
        e = q.pop_front();
        chk("cdb_valid4", 64'(cv), 64'(e.v[0]));
        chk("cdb_value4", 64'(cval), 64'(e.val[0]));
        chk("cdb_tag4", 64'(ctag), 64'(e.tag[0]));
        chk("cdb_wr_en4", 64'(cwe), 64'(e.we[0]));
        chk("cdb_valid3", 64'(cv3), 64'(e.v[1]));
        chk("cdb_value3", 64'(cval3), 64'(e.val[1]));
        chk("cdb_tag3", 64'(ctag3), 64'(e.tag[1]));
        chk("cdb_wr_en3", 64'(cwe3), 64'(e.we[1]));
      end
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0; stl = 1'b0;
    fv = '0; fwe = '0; fres = '0; ftag = '0;
    fv3 = '0; fwe3 = '0; fres3 = '0; ftag3 = '0;
    for (int u = 0; u < 2; u++) begin
      mp[u] = 0; mv[u] = 1'b0; mval[u] = '0; mtag[u] = '0; mwe[u] = 1'b0;
    end
    step(4'h0, 3'h0, 1'b0, 1'b0, 1'b1);
    step(4'hF, 3'h7, 1'b0, 1'b0, 1'b1);
    // single requester
    step(4'b0100, 3'b100, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 3'b000, 1'b0, 1'b0, 1'b0);
    // back-to-back round robin, including 3-FU wrap
    step(4'h0, 3'h0, 1'b0, 1'b0, 1'b1);
    repeat (6) step(4'hF, 3'h7, 1'b0, 1'b0, 1'b0);
    step(4'h0, 3'h0, 1'b0, 1'b0, 1'b0);
    // stall holds the CDB, then FU1 goes through
    step(4'b0001, 3'b001, 1'b0, 1'b0, 1'b0);
    repeat (3) step(4'b0010, 3'b010, 1'b0, 1'b1, 1'b0);
    step(4'b0010, 3'b010, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 3'b000, 1'b0, 1'b0, 1'b0);
    // clear, and clear together with stall
    step(4'b0100, 3'b100, 1'b0, 1'b0, 1'b0);
    step(4'b0001, 3'b001, 1'b1, 1'b0, 1'b0);
    step(4'b1000, 3'b010, 1'b0, 1'b0, 1'b0);
    step(4'hF, 3'h7, 1'b1, 1'b1, 1'b0);
    step(4'h0, 3'h0, 1'b0, 1'b0, 1'b0);
    // reset mid-stream
    step(4'hF, 3'h7, 1'b0, 1'b0, 1'b0);
    step(4'hF, 3'h7, 1'b0, 1'b0, 1'b0);
    step(4'hF, 3'h7, 1'b0, 1'b0, 1'b1);
    step(4'hF, 3'h7, 1'b0, 1'b0, 1'b0);
    step(4'hF, 3'h7, 1'b0, 1'b0, 1'b0);
    // random traffic
    repeat (3000)
      step(4'($urandom), 3'($urandom),
           $urandom_range(9, 0) == 0,
           $urandom_range(7, 0) == 0,
           $urandom_range(99, 0) == 0);
    repeat (3) @(posedge clk);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single Common Data Bus (CDB) between NUM_FU function units (ALUs and peers) that each hold one completed result.
- Picks one holding FU per cycle by round-robin and returns a same-cycle broadcasted acknowledge to the winner, which frees that FU.
- Registers the winning result, tag and write-enable onto the CDB one cycle later, for the PRF, RS wakeup and ROB.

Parameters:
- NUM_FU, 4, number of requesting function units; legal range 2..16, power of two not required.
- PHYS_REG_WIDTH, 6, width of physical register tags.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  squash: drop the pending CDB result and issue no grant this cycle.
- cdb_stall  input  1  consumer cannot accept a broadcast: issue no grant and hold the CDB registers.
- fu_valid  input  NUM_FU  bit i = FU i holds a valid result this cycle (FU registered valid).
- fu_result  input  NUM_FU x DATA  result held by each FU.
- fu_dest_tag  input  NUM_FU x PHYS_REG_WIDTH  destination tag of each FU.
- fu_dest_tag_wr_en  input  NUM_FU  PRF write-enable from each FU.
- fu_broadcasted  output  NUM_FU  one-hot (or zero) grant; combinational, same cycle as fu_valid.
- cdb_valid  output  1  CDB carries a valid broadcast.
- cdb_value  output  DATA  broadcast result.
- cdb_tag  output  PHYS_REG_WIDTH  broadcast destination tag.
- cdb_wr_en  output  1  broadcast PRF write-enable.

Behaviour:
- Reset (synchronous, active-high): cdb_valid=0, cdb_value=0, cdb_tag=0, cdb_wr_en=0, priority pointer ptr=0. fu_broadcasted=0 while reset=1.
- State:
  - ptr, $clog2(NUM_FU) bits, minimum 1.
  - CDB output registers.
- Grant (combinational):
  - If reset, clear or cdb_stall is 1: fu_broadcasted=0.
  - Otherwise: the first i with fu_valid[i]=1, searched in order ptr, ptr+1, …, NUM_FU-1, 0, …, ptr-1, gets fu_broadcasted[i]=1.
  - At most one bit is ever set.
  - fu_valid=0 -> no grant.
- Pointer update:
  - On a grant to i, ptr <= (i+1) mod NUM_FU. Wraps explicitly; must be correct for non-power-of-two NUM_FU, e.g. NUM_FU=3 with i=2 gives ptr=0.
  - No grant -> ptr holds.
  - clear does not move ptr.
- CDB registers, priority order:
  1. reset -> zeros.
  2. clear -> cdb_valid<=0; value, tag and wr_en may hold.
  3. cdb_stall -> all hold.
  4. grant to i -> cdb_valid<=1; cdb_value, cdb_tag, cdb_wr_en <= FU i fields.
  5. Otherwise -> cdb_valid<=0.
- Latency: fu_valid[i] high and granted in cycle N -> cdb_valid=1 with FU i data in cycle N+1. Sustained throughput is one broadcast per cycle.
- A grant is issued even when fu_dest_tag_wr_en[i]=0; cdb_wr_en carries 0 for that broadcast.
- Fairness: a continuously requesting FU waits at most NUM_FU-1 grants.
- Simultaneous clear and cdb_stall: clear wins, so cdb_valid<=0.
- A granted FU drops its fu_valid the next cycle (it saw broadcasted). The arbiter does not depend on this; it always re-evaluates fu_valid.
- Reset mid-stream: any pending CDB entry is discarded, ptr returns to 0, and no grant is issued in the reset cycle.

Test Plan:
- Single requester: fu_valid=4'b0100, result 32'h1234, tag 6'd9, wr_en=1 -> fu_broadcasted=4'b0100 same cycle. Next cycle: cdb_valid=1, cdb_value=32'h1234, cdb_tag=9, cdb_wr_en=1, ptr=3.
- Round-robin, 4 FUs all valid held for 6 cycles from reset -> grants 0,1,2,3,0,1. cdb_valid=1 for 6 consecutive cycles starting one cycle after the first grant.
- Wrap with NUM_FU=3, all valid -> grants 0,1,2,0. ptr is never 3.
- Stall: a broadcast of tag 5 is on the CDB, then cdb_stall=1 for 3 cycles with FU1 valid -> fu_broadcasted=0, CDB holds tag 5 with cdb_valid=1. On release, FU1 is granted and its data appears the next cycle.
- Clear: FU2 granted in cycle N, clear=1 in cycle N+1 -> cdb_valid=0 at N+2 and no grant in N+1. clear together with cdb_stall also gives cdb_valid=0.
- Reset mid-operation: ptr=2 and cdb_valid=1, then reset for 1 cycle with all fu_valid=1 -> fu_broadcasted=0 and CDB outputs zero. After reset the first grant goes to FU0.
